// File: rtl/fill_pkg.sv
// Shared opcodes and FSM state encoding for the memory fill engine.
package fill_pkg;

  localparam logic [7:0] OP_NOP      = 8'h00;
  localparam logic [7:0] OP_CLEAR    = 8'h01;
  localparam logic [7:0] OP_CLEAR_TO = 8'h02;
  localparam logic [7:0] OP_FILL     = 8'h03;
  localparam logic [7:0] OP_PATTERN  = 8'h04;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fill_engine_range_walker.sv
// Ascending address walker with inclusive end detection; the address never
// wraps because the owner stops stepping once last_o is high.
module range_walker #(
  parameter int ADDR_W = 16,
  parameter int OFF_W  = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] start_i,
  input  logic [ADDR_W-1:0] end_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [OFF_W-1:0]  offset_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] end_q;
  logic [OFF_W-1:0]  offset_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= '0;
      end_q    <= '0;
      offset_q <= '0;
    end else if (load_i) begin
      addr_q   <= start_i;
      end_q    <= end_i;
      offset_q <= '0;
    end else if (step_i) begin
      addr_q   <= addr_q + ADDR_W'(1);
      offset_q <= offset_q + OFF_W'(1);
    end
  end

  assign addr_o   = addr_q;
  assign offset_o = offset_q;
  assign last_o   = (addr_q == end_q);

endmodule

// File: rtl/fill_engine.sv
// Command-driven clear/fill/pattern engine driving the video-memory write port.
module fill_engine
  import fill_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [7:0]        cmd,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] arg_start,
  input  logic [ADDR_W-1:0] arg_end,
  input  logic [DATA_W-1:0] arg_data,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              err
);

  state_t            state_q;
  logic              cmd_ready_q, busy_q, mem_wren_q, done_q, aborted_q, err_q;
  logic              pattern_q;
  logic [DATA_W-1:0] seed_q, mem_data_q;

  logic              accept, reject, ranged, walk_load, walk_step, walk_last;
  logic [ADDR_W-1:0] start_sel, end_sel;
  logic [DATA_W-1:0] walk_offset;

  always_comb begin
    accept    = cmd_valid && cmd_ready_q;
    ranged    = (cmd == OP_FILL) || (cmd == OP_PATTERN);
    reject    = (cmd > OP_PATTERN) || (ranged && (arg_start > arg_end));
    start_sel = ranged ? arg_start : '0;
    end_sel   = (cmd == OP_CLEAR) ? '1 : arg_end;
    walk_load = (state_q == ST_IDLE) && accept && !reject && (cmd != OP_NOP);
    walk_step = (state_q == ST_RUN) && !abort && !walk_last;
  end

  range_walker #(.ADDR_W(ADDR_W), .OFF_W(DATA_W)) u_walker (
    .clock    (clock),
    .reset_n  (reset_n),
    .load_i   (walk_load),
    .step_i   (walk_step),
    .start_i  (start_sel),
    .end_i    (end_sel),
    .addr_o   (mem_addr),
    .offset_o (walk_offset),
    .last_o   (walk_last)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      mem_wren_q  <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      err_q       <= 1'b0;
      pattern_q   <= 1'b0;
      seed_q      <= '0;
      mem_data_q  <= '0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (reject) begin
              err_q <= 1'b1;
            end else if (cmd == OP_NOP) begin
              state_q     <= ST_DONE;
              busy_q      <= 1'b1;
              cmd_ready_q <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              state_q     <= ST_RUN;
              busy_q      <= 1'b1;
              cmd_ready_q <= 1'b0;
              mem_wren_q  <= 1'b1;
              pattern_q   <= (cmd == OP_PATTERN);
              seed_q      <= ranged ? arg_data : '0;
              mem_data_q  <= ranged ? arg_data : '0;
            end
          end
        end
        ST_RUN: begin
          // The word on the port this cycle completes even when abort is seen.
          if (abort || walk_last) begin
            state_q    <= ST_DONE;
            mem_wren_q <= 1'b0;
            done_q     <= 1'b1;
            aborted_q  <= abort;
          end else if (pattern_q) begin
            mem_data_q <= seed_q + walk_offset + DATA_W'(1);
          end
        end
        ST_DONE: begin
          state_q     <= ST_IDLE;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign mem_wren  = mem_wren_q;
  assign mem_data  = mem_data_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fill_engine.sv
// Directed bench: a 4-bit-address engine for full CLEAR/reset cases and a
// 16-bit-address engine for ranged FILL/PATTERN/abort/error cases.
module tb_fill_engine;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  cmd = 8'h00;
  logic        valid_s = 1'b0, valid_b = 1'b0;
  logic [15:0] arg_start = '0, arg_end = '0;
  logic [7:0]  arg_data = '0;
  logic        abort = 1'b0;

  logic        ready_s, wren_s, busy_s, done_s, abrt_s, err_s;
  logic [3:0]  addr_s;
  logic [7:0]  data_s;
  logic        ready_b, wren_b, busy_b, done_b, abrt_b, err_b;
  logic [15:0] addr_b;
  logic [7:0]  data_b;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clock = ~clock;

  fill_engine #(.ADDR_W(4), .DATA_W(8)) dut_s (
    .clock(clock), .reset_n(reset_n), .cmd(cmd), .cmd_valid(valid_s), .cmd_ready(ready_s),
    .arg_start(arg_start[3:0]), .arg_end(arg_end[3:0]), .arg_data(arg_data), .abort(abort),
    .mem_addr(addr_s), .mem_data(data_s), .mem_wren(wren_s), .busy(busy_s),
    .done(done_s), .aborted(abrt_s), .err(err_s)
  );

  fill_engine #(.ADDR_W(16), .DATA_W(8)) dut_b (
    .clock(clock), .reset_n(reset_n), .cmd(cmd), .cmd_valid(valid_b), .cmd_ready(ready_b),
    .arg_start(arg_start), .arg_end(arg_end), .arg_data(arg_data), .abort(abort),
    .mem_addr(addr_b), .mem_data(data_b), .mem_wren(wren_b), .busy(busy_b),
    .done(done_b), .aborted(abrt_b), .err(err_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue_b(input logic [7:0] c, input logic [15:0] s, input logic [15:0] e,
                         input logic [7:0] d);
    cmd = c; arg_start = s; arg_end = e; arg_data = d; valid_b = 1'b1;
    $display("cmd big   op=%02h start=%04h end=%04h data=%02h", c, s, e, d);
    tick();
    valid_b = 1'b0;
  endtask

  task automatic issue_s(input logic [7:0] c, input logic [15:0] e);
    cmd = c; arg_start = '0; arg_end = e; arg_data = 8'h00; valid_s = 1'b1;
    $display("cmd small op=%02h end=%04h", c, e);
    tick();
    valid_s = 1'b0;
  endtask

  task automatic check_reject(input string tag);
    check({tag, " err"}, err_b, 1);
    check({tag, " wren"}, wren_b, 0);
    check({tag, " done"}, done_b, 0);
    check({tag, " ready"}, ready_b, 1);
    tick();
    check({tag, " err clr"}, err_b, 0);
    check({tag, " wren2"}, wren_b, 0);
    check({tag, " done2"}, done_b, 0);
  endtask

  logic [7:0] pat_exp [4];

  initial begin
    pat_exp[0] = 8'hFE; pat_exp[1] = 8'hFF; pat_exp[2] = 8'h00; pat_exp[3] = 8'h01;

    // Reset values
    tick(); tick();
    check("rst ready", {ready_s, ready_b}, 2'b11);
    check("rst busy", {busy_s, busy_b}, 2'b00);
    check("rst wren", {wren_s, wren_b}, 2'b00);
    check("rst done/abrt/err", {done_s, abrt_s, err_s, done_b, abrt_b, err_b}, 6'b0);
    check("rst addr", {addr_s, addr_b}, 20'h0);
    check("rst data", {data_s, data_b}, 16'h0);
    #3 reset_n = 1'b1;
    tick();

    // CLEAR on 4-bit engine: 16 writes of 0, no rewrite of address 0
    issue_s(8'h01, 16'h0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("clr wren %0d", i), wren_s, 1);
      check($sformatf("clr addr %0d", i), addr_s, i);
      check($sformatf("clr data %0d", i), data_s, 0);
      tick();
    end
    check("clr wren end", wren_s, 0);
    check("clr done", done_s, 1);
    check("clr aborted", abrt_s, 0);
    check("clr busy in done", busy_s, 1);
    tick();
    check("clr done clr", done_s, 0);
    check("clr ready back", ready_s, 1);
    check("clr wren idle", wren_s, 0);

    // FILL 0x10..0x13 with 0xA5; a NOP held valid while busy must be ignored
    issue_b(8'h03, 16'h0010, 16'h0013, 8'hA5);
    cmd = 8'h00; valid_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fill wren %0d", i), wren_b, 1);
      check($sformatf("fill addr %0d", i), addr_b, 16'h0010 + i);
      check($sformatf("fill data %0d", i), data_b, 8'hA5);
      check($sformatf("fill ready %0d", i), ready_b, 0);
      tick();
    end
    valid_b = 1'b0;
    check("fill done N+5", done_b, 1);
    check("fill wren N+5", wren_b, 0);
    check("fill ready N+5", ready_b, 0);
    tick();
    check("fill ready N+6", ready_b, 1);
    check("fill done N+6", done_b, 0);
    check("fill busy N+6", busy_b, 0);
    check("fill no queued cmd", wren_b, 0);

    // PATTERN 0xFE..0x101 seed 0xFE
    issue_b(8'h04, 16'h00FE, 16'h0101, 8'hFE);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pat wren %0d", i), wren_b, 1);
      check($sformatf("pat addr %0d", i), addr_b, 16'h00FE + i);
      check($sformatf("pat data %0d", i), data_b, pat_exp[i]);
      tick();
    end
    check("pat done", {wren_b, done_b, abrt_b}, 3'b010);
    tick();
    check("pat ready", ready_b, 1);

    // FILL 0..0xFF, abort during the third write cycle
    issue_b(8'h03, 16'h0000, 16'h00FF, 8'h3C);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("abt wren %0d", i), wren_b, 1);
      check($sformatf("abt addr %0d", i), addr_b, i);
      if (i == 2) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    check("abt wren off", wren_b, 0);
    check("abt done", done_b, 1);
    check("abt aborted", abrt_b, 1);
    tick();
    check("abt ready", ready_b, 1);
    check("abt pulses clr", {done_b, abrt_b, wren_b}, 3'b000);

    // Rejected commands
    issue_b(8'h07, 16'h0000, 16'h0003, 8'h11);
    check_reject("badop");
    issue_b(8'h03, 16'h0005, 16'h0004, 8'h22);
    check_reject("badrange");

    // Reset asserted mid-CLEAR, then NOP
    issue_s(8'h01, 16'h0);
    tick(); tick();
    check("mid wren before rst", wren_s, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst async wren", wren_s, 0);
    check("rst async ready", ready_s, 1);
    #2 reset_n = 1'b1;
    tick();
    check("post rst idle", {ready_s, busy_s, done_s, wren_s}, 4'b1000);
    issue_s(8'h00, 16'h0);
    check("nop done N+1", done_s, 1);
    check("nop no write", wren_s, 0);
    check("nop aborted", abrt_s, 0);
    tick();
    check("nop done clr", done_s, 0);
    tick();
    check("nop ready", ready_s, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
